// File: rtl/mem_loader.sv
// mem_loader: framed serial loader (sync, count, data, checksum) for program memory.
// Define MEM_LOADER_CHECKSUM_EN to require and verify the trailing checksum byte.
module mem_loader #(
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_bus_en,
  output logic                  o_write_n,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [1:0]            o_err_code
);

  localparam int NW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DATA_WIDTH-1:0] DEPTH =
    DATA_WIDTH'(2 ** ADDR_WIDTH);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_CNT  = 2'b01;
  localparam logic [1:0] E_SUM  = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_COUNT,
    S_DATA,
    S_WRITE,
`ifdef MEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NW-1:0]         n_q, n_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  bus_d;
  logic                  wr_n_d;
  logic                  hold_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  error_d;
  logic [1:0]            code_d;

  logic                  timed;
  logic                  tmo_hit;
  logic                  cnt_ok;
  logic                  go_err;
  logic                  go_done;
  logic [1:0]            err_sel;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] csum;
  assign csum = sum_q + i_rx_data;
`endif

  // WRITE belongs to the idle gap after a data byte, so it keeps counting.
  always_comb begin
    timed = 1'b0;
    unique case (state_q)
      S_COUNT, S_DATA, S_WRITE: timed = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CSUM:                   timed = 1'b1;
`endif
      default:                  timed = 1'b0;
    endcase
  end

  assign tmo_hit = timed && (tmo_q == TMO_LAST);
  assign cnt_ok  = (i_rx_data != '0) &&
                   (i_rx_data <= DEPTH);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    n_d       = n_q;
    tmo_d     = timed ? tmo_q + 1'b1 : '0;
    address_d = o_address;
    data_d    = o_data;
    bus_d     = o_bus_en;
    wr_n_d    = o_write_n;
    hold_d    = o_cpu_hold;
    busy_d    = o_busy;
    done_d    = o_done;
    error_d   = o_error;
    code_d    = o_err_code;
    go_err    = 1'b0;
    go_done   = 1'b0;
    err_sel   = E_NONE;
`ifdef MEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d = S_SYNC;
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = E_NONE;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_SYNC: begin
        if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
          state_d = S_COUNT;
          tmo_d   = '0;
        end
      end
      S_COUNT: begin
        if (i_rx_valid) begin
          tmo_d = '0;
          if (cnt_ok) begin
            n_d     = i_rx_data[NW-1:0];
            addr_d  = '0;
            state_d = S_DATA;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            go_err  = 1'b1;
            err_sel = E_CNT;
          end
        end else if (tmo_hit) begin
          go_err  = 1'b1;
          err_sel = E_TMO;
        end
      end
      S_DATA: begin
        if (i_rx_valid) begin
          data_d    = i_rx_data;
          address_d = addr_q;
          wr_n_d    = 1'b0;
          bus_d     = 1'b1;
          tmo_d     = '0;
          state_d   = S_WRITE;
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d     = sum_q + i_rx_data;
`endif
        end else if (tmo_hit) begin
          go_err  = 1'b1;
          err_sel = E_TMO;
        end
      end
      S_WRITE: begin
        wr_n_d = 1'b1;
        bus_d  = 1'b0;
        addr_d = addr_q + 1'b1;
        n_d    = n_q - 1'b1;
        if (i_rx_valid) begin
          go_err  = 1'b1;
          err_sel = E_TMO;
        end else if (n_q == NW'(1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          go_done = 1'b1;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (i_rx_valid) begin
          tmo_d = '0;
          if (csum == '0) begin
            go_done = 1'b1;
          end else begin
            go_err  = 1'b1;
            err_sel = E_SUM;
          end
        end else if (tmo_hit) begin
          go_err  = 1'b1;
          err_sel = E_TMO;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A failed load keeps the CPU halted on a partial program.
    if (go_err) begin
      state_d = S_ERROR;
      error_d = 1'b1;
      busy_d  = 1'b0;
      code_d  = err_sel;
    end
    if (go_done) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      n_q        <= '0;
      tmo_q      <= '0;
      o_address  <= '0;
      o_data     <= '0;
      o_bus_en   <= 1'b0;
      o_write_n  <= 1'b1;
      o_cpu_hold <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_err_code <= E_NONE;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      tmo_q      <= tmo_d;
      o_address  <= address_d;
      o_data     <= data_d;
      o_bus_en   <= bus_d;
      o_write_n  <= wr_n_d;
      o_cpu_hold <= hold_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_error    <= error_d;
      o_err_code <= code_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed frames against mem_loader with a write-port monitor.
// Expected values follow MEM_LOADER_CHECKSUM_EN when it is defined.
module tb_mem_loader;

  localparam int TMO = 20;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_valid = 1'b0;
  logic [3:0] o_address;
  logic [7:0] o_data;
  logic       o_bus_en;
  logic       o_write_n;
  logic       o_cpu_hold;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [1:0] o_err_code;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] log_a [64];
  logic [7:0] log_d [64];
  int n_wr = 0;
  int low_run = 0;
  int long_pulse = 0;
  int bus_bad = 0;

  always #5 i_clk = ~i_clk;

  mem_loader #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_address  (o_address),
    .o_data     (o_data),
    .o_bus_en   (o_bus_en),
    .o_write_n  (o_write_n),
    .o_cpu_hold (o_cpu_hold),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error),
    .o_err_code (o_err_code)
  );

  // Memory side: captures whatever is on the port at each rising edge.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      if (o_bus_en !== ~o_write_n)
        bus_bad <= bus_bad + 1;
      if (o_write_n === 1'b0) begin
        if (n_wr < 64) begin
          log_a[n_wr] <= o_address;
          log_d[n_wr] <= o_data;
        end
        n_wr <= n_wr + 1;
        low_run <= low_run + 1;
        if (low_run >= 1)
          long_pulse <= long_pulse + 1;
      end else begin
        low_run <= 0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_wr_n"}, o_write_n, 1);
    chk({t, "_bus"}, o_bus_en, 0);
    chk({t, "_addr"}, o_address, 0);
    chk({t, "_data"}, o_data, 0);
    chk({t, "_hold"}, o_cpu_hold, 0);
    chk({t, "_busy"}, o_busy, 0);
    chk({t, "_done"}, o_done, 0);
    chk({t, "_err"}, o_error, 0);
    chk({t, "_code"}, o_err_code, 0);
  endtask

  task automatic start_pulse();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    logic [7:0] d;
    logic [7:0] sum;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h1D;
    exp_d[1] = 8'h61;
    exp_d[2] = 8'h40;

    #2 i_rst = 1'b1;
    @(negedge i_clk);
    chk_rst("rst");
    i_rst = 1'b0;

    // basic 3-byte frame
    start_pulse();
    chk("t1_busy", o_busy, 1);
    chk("t1_hold", o_cpu_hold, 1);
    base = n_wr;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h1D);
    send_byte(8'h61);
    send_byte(8'h40);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("t1_wait_csum", o_busy, 1);
    send_byte(8'h42);
`endif
    chk("t1_nwr", n_wr - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", log_a[base+i], i);
      chk("t1_data", log_d[base+i], exp_d[i]);
    end
    chk("t1_done", o_done, 1);
    chk("t1_hold_off", o_cpu_hold, 0);
    chk("t1_busy_off", o_busy, 0);
    chk("t1_code", o_err_code, 0);

    // bad checksum byte
    start_pulse();
    chk("t2_clr_done", o_done, 0);
    base = n_wr;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h1D);
    send_byte(8'h61);
    send_byte(8'h40);
    send_byte(8'h43);
    chk("t2_nwr", n_wr - base, 3);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("t2_err", o_error, 1);
    chk("t2_code", o_err_code, 2);
    chk("t2_hold", o_cpu_hold, 1);
    chk("t2_done", o_done, 0);
`else
    chk("t2_done", o_done, 1);
    chk("t2_err", o_error, 0);
    chk("t2_code", o_err_code, 0);
`endif

    // junk before sync, then count too large
    start_pulse();
    chk("t3_clr_err", o_error, 0);
    base = n_wr;
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("t3_still_busy", o_busy, 1);
    send_byte(8'hA5);
    send_byte(8'h11);
    chk("t3_nwr", n_wr - base, 0);
    chk("t3_err", o_error, 1);
    chk("t3_code", o_err_code, 1);
    chk("t3_hold", o_cpu_hold, 1);
    chk("t3_busy", o_busy, 0);

    // zero count
    start_pulse();
    chk("t3b_clr_code", o_err_code, 0);
    send_byte(8'hA5);
    send_byte(8'h00);
    chk("t3b_err", o_error, 1);
    chk("t3b_code", o_err_code, 1);

    // full 16-byte frame
    start_pulse();
    base = n_wr;
    send_byte(8'hA5);
    send_byte(8'h10);
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 7 + 3);
      sum = sum + d;
      send_byte(d);
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(8'(8'h00 - sum));
`endif
    chk("t4_nwr", n_wr - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t4_addr", log_a[base+i], i);
      chk("t4_data", log_d[base+i], 8'(i * 7 + 3));
    end
    chk("t4_done", o_done, 1);
    chk("t4_code", o_err_code, 0);
    chk("t4_last_addr", o_address, 4'hF);

    // timeout after one data byte
    start_pulse();
    base = n_wr;
    send_byte(8'hA5);
    send_byte(8'h02);
    @(negedge i_clk);
    i_rx_data  = 8'h5A;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1 i_rx_valid = 1'b0;
    cnt = 0;
    while (o_error !== 1'b1 && cnt < 40) begin
      @(posedge i_clk);
      cnt++;
      #1;
    end
    chk("t5_cycles", cnt, TMO);
    chk("t5_code", o_err_code, 3);
    chk("t5_hold", o_cpu_hold, 1);
    chk("t5_nwr", n_wr - base, 1);
    chk("t5_data", log_d[base], 8'h5A);

    // reset during the second data write
    start_pulse();
    base = n_wr;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h77);
    i_rx_data  = 8'h88;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1 i_rx_valid = 1'b0;
    chk("t6_wr_low", o_write_n, 0);
    chk("t6_wr_addr", o_address, 1);
    chk("t6_wr_data", o_data, 8'h88);
    i_rst = 1'b1;
    #1;
    chk_rst("t6_rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("t6_nwr", n_wr - base, 1);

    start_pulse();
    base = n_wr;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(8'hCD);
`endif
    chk("t6b_nwr", n_wr - base, 2);
    chk("t6b_a0", log_a[base], 0);
    chk("t6b_d0", log_d[base], 8'h11);
    chk("t6b_a1", log_a[base+1], 1);
    chk("t6b_d1", log_d[base+1], 8'h22);
    chk("t6b_done", o_done, 1);
    chk("t6b_hold", o_cpu_hold, 0);

    chk("long_pulse", long_pulse, 0);
    chk("bus_en_inv", bus_bad, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
